// File: rtl/token_table_loader.sv
// token_table_loader: streams token words from a valid/ready input into
// consecutive token-table entries (address wraps modulo SIZE).
// Optional read-back checksum pass: define TOKEN_LOADER_VERIFY_EN.
module token_table_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64,
    parameter int CNT_W = $clog2(SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tbl_addr,
    output logic [WIDTH-1:0] tbl_data,
    output logic             tbl_we,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_written
`ifdef TOKEN_LOADER_VERIFY_EN
    ,
    output logic [WIDTH-1:0] tbl_rd_addr,
    input  logic [WIDTH-1:0] tbl_rd_data
`endif
);

    localparam int AW = $clog2(SIZE);

`ifdef TOKEN_LOADER_VERIFY_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_VERIFY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [AW-1:0]    base_q, base_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             error_q, error_d;
    logic             accept;
    logic [CNT_W-1:0] words_inc;
    logic [AW-1:0]    wr_addr;
    logic             unused_base_hi;

`ifdef TOKEN_LOADER_VERIFY_EN
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [WIDTH-1:0] rsum_q, rsum_d;
    logic [CNT_W-1:0] vidx_q, vidx_d;
    logic [CNT_W-1:0] vidx_inc;
    logic [AW-1:0]    rd_addr;

    assign vidx_inc    = vidx_q + 1'b1;
    assign rd_addr     = base_q + vidx_q[AW-1:0];
    assign tbl_rd_addr = (state_q == S_VERIFY) ? WIDTH'(rd_addr) : '0;
`endif

    // Only the low address bits select an entry.
    assign unused_base_hi = ^base_addr[WIDTH-1:AW];

    assign words_inc     = words_q + 1'b1;
    assign wr_addr       = base_q + words_q[AW-1:0];
    assign tbl_we        = accept;
    assign tbl_addr      = accept ? WIDTH'(wr_addr) : '0;
    assign tbl_data      = accept ? in_data : '0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign error         = error_q;
    assign words_written = words_q;

    // Next-state, handshake and bookkeeping logic.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        words_d  = words_q;
        error_d  = error_q;
        in_ready = 1'b0;
        accept   = 1'b0;
`ifdef TOKEN_LOADER_VERIFY_EN
        csum_d   = csum_q;
        rsum_d   = rsum_q;
        vidx_d   = vidx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count > CNT_W'(SIZE)) begin
                        error_d = 1'b1;
                    end else if (count == '0) begin
                        error_d = 1'b0;
                        words_d = '0;
                        state_d = S_DONE;
                    end else begin
                        base_d  = base_addr[AW-1:0];
                        count_d = count;
                        words_d = '0;
                        error_d = 1'b0;
`ifdef TOKEN_LOADER_VERIFY_EN
                        csum_d  = '0;
`endif
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // Abort wins over a simultaneous beat: drop ready so it is not taken.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept  = 1'b1;
                        words_d = words_inc;
`ifdef TOKEN_LOADER_VERIFY_EN
                        csum_d  = csum_q ^ in_data;
                        if (words_inc == count_q) begin
                            vidx_d  = '0;
                            rsum_d  = '0;
                            state_d = S_VERIFY;
                        end
`else
                        if (words_inc == count_q) begin
                            state_d = S_DONE;
                        end
`endif
                    end
                end
            end
`ifdef TOKEN_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rsum_d = rsum_q ^ tbl_rd_data;
                    vidx_d = vidx_inc;
                    if (vidx_inc == count_q) begin
                        if (rsum_d != csum_q) begin
                            error_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            words_q <= '0;
            error_q <= 1'b0;
`ifdef TOKEN_LOADER_VERIFY_EN
            csum_q  <= '0;
            rsum_q  <= '0;
            vidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            words_q <= words_d;
            error_q <= error_d;
`ifdef TOKEN_LOADER_VERIFY_EN
            csum_q  <= csum_d;
            rsum_q  <= rsum_d;
            vidx_q  <= vidx_d;
`endif
        end
    end

endmodule

// File: tb/tb_token_table_loader.sv
// Directed + randomized bench for token_table_loader with a behavioural table
// model and an expected-contents array derived from base/count/word lists.
module tb_token_table_loader;

    localparam int WIDTH = 32;
    localparam int SIZE  = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] base_addr;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] tbl_addr;
    logic [WIDTH-1:0] tbl_data;
    logic             tbl_we;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_written;

    logic [WIDTH-1:0] mem     [SIZE] = '{default: '0};
    logic [WIDTH-1:0] exp_mem [SIZE] = '{default: '0};
    logic [WIDTH-1:0] wq [$];
    int               total = 0;
    int               bad   = 0;
    int               nwrites = 0;

`ifdef TOKEN_LOADER_VERIFY_EN
    logic [WIDTH-1:0] tbl_rd_addr;
    logic [WIDTH-1:0] tbl_rd_data;
    logic             corrupt = 1'b0;
    assign tbl_rd_data = mem[int'(tbl_rd_addr % SIZE)] ^
                         ((corrupt && tbl_rd_addr == 2) ? 32'h1 : 32'h0);
`endif

    token_table_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .count(count), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .tbl_we(tbl_we), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
`ifdef TOKEN_LOADER_VERIFY_EN
        , .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data)
`endif
    );

    always #5 clk = ~clk;

    // Table model: synchronous write port.
    always @(posedge clk) begin
        if (tbl_we) begin
            mem[int'(tbl_addr % SIZE)] <= tbl_data;
            nwrites <= nwrites + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic check_table();
        for (int i = 0; i < SIZE; i++) check("table", mem[i], exp_mem[i]);
    endtask

    // gap: 0 = valid held high, 1 = valid every other cycle, 2 = random valid
    task automatic do_xfer(input int base, input int cnt, input int gap, input bit exp_err);
        int k;
        int cyc;
        int nw0;
        nw0       = nwrites;
        base_addr = WIDTH'(base);
        count     = CNT_W'(cnt);
        start     = 1'b1;
        tick();
        start = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < cnt && cyc < 400) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? wq[k] : $urandom;
            @(negedge clk);
            check("ready_load", in_ready, 1);
            check("busy_load", busy, 1);
            if (in_valid) begin
                check("we_beat", tbl_we, 1);
                check("addr_beat", tbl_addr, (base + k) % SIZE);
                check("data_beat", tbl_data, wq[k]);
                exp_mem[(base + k) % SIZE] = wq[k];
                k++;
            end else begin
                check("we_novalid", tbl_we, 0);
            end
            tick();
            cyc++;
        end
        check("load_complete", k, cnt);
        in_valid = 1'b0;
`ifdef TOKEN_LOADER_VERIFY_EN
        for (int j = 0; j < cnt; j++) begin
            @(negedge clk);
            check("ready_verify", in_ready, 0);
            check("done_verify", done, 0);
            check("rd_addr", tbl_rd_addr, (base + j) % SIZE);
            tick();
        end
`endif
        @(negedge clk);
        check("done_pulse", done, 1);
        check("ready_done", in_ready, 0);
        check("error_done", error, exp_err);
        check("words_written", words_written, cnt);
        check("write_count", nwrites - nw0, cnt);
        tick();
        @(negedge clk);
        check("done_low", done, 0);
        check("busy_idle", busy, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        check("rst_ready", in_ready, 0);
        check("rst_we", tbl_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", tbl_addr, 0);
        check("rst_data", tbl_data, 0);
        check("rst_words", words_written, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // base 0, words 1..5, valid held
        wq.delete();
        for (int i = 1; i <= 5; i++) wq.push_back(WIDTH'(i));
        do_xfer(0, 5, 0, 1'b0);
        check_table();

        // same transfer, valid every other cycle
        do_xfer(0, 5, 1, 1'b0);

        // wrap around the end of the table
        wq.delete();
        wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC); wq.push_back(32'hD);
        do_xfer(62, 4, 0, 1'b0);

        // oversized count: error, stays idle, no done
        base_addr = '0; count = CNT_W'(SIZE + 1); start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("big_busy", busy, 0);
        check("big_error", error, 1);
        check("big_done", done, 0);
        tick();

        // zero count: immediate done, error cleared, no writes
        begin
            int nw0;
            nw0 = nwrites;
            count = '0; start = 1'b1;
            tick();
            start = 1'b0;
            @(negedge clk);
            check("zero_done", done, 1);
            check("zero_we", tbl_we, 0);
            check("zero_error", error, 0);
            tick();
            @(negedge clk);
            check("zero_idle", busy, 0);
            check("zero_writes", nwrites - nw0, 0);
            tick();
        end

        // abort beats a simultaneous beat
        fill_random(4);
        base_addr = WIDTH'(5); count = CNT_W'(4); start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = wq[0];
        @(negedge clk);
        check("abort_we0", tbl_we, 1);
        exp_mem[5] = wq[0];
        tick();
        abort = 1'b1; in_data = wq[1];
        @(negedge clk);
        check("abort_ready", in_ready, 0);
        check("abort_we", tbl_we, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_words", words_written, 1);
        tick();

        // reset mid-transfer after two beats
        fill_random(5);
        base_addr = WIDTH'(20); count = CNT_W'(5); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = wq[i];
            @(negedge clk);
            check("rst_mid_we", tbl_we, 1);
            exp_mem[20 + i] = wq[i];
            tick();
        end
        in_data = wq[2];
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", in_ready, 0);
        check("rst_mid_tblwe", tbl_we, 0);
        check("rst_mid_words", words_written, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        wq.delete();
        wq.push_back(32'd7);
        do_xfer(10, 1, 0, 1'b0);
        check("addr10", mem[10], 32'd7);

        // randomized transfers
        for (int t = 0; t < 4; t++) begin
            int b;
            int c;
            b = $urandom_range(0, SIZE - 1);
            c = $urandom_range(1, SIZE);
            fill_random(c);
            do_xfer(b, c, 2, 1'b0);
        end
        do_xfer(0, 0, 0, 1'b0);

`ifdef TOKEN_LOADER_VERIFY_EN
        corrupt = 1'b1;
        fill_random(5);
        do_xfer(0, 5, 0, 1'b1);
        corrupt = 1'b0;
        fill_random(5);
        do_xfer(0, 5, 0, 1'b0);
`endif

        check_table();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/token_table_loader.md
Name: token_table_loader

Overview:
- Write-side companion to the token table.
- Accepts a stream of token words over a valid/ready handshake and writes them into consecutive table entries through the table's write port (address, data, enable). The start entry and word count are given per transfer; addresses wrap modulo SIZE.
- Sits between the configuration/boot path and the token table, so decode tokens can be loaded at run time instead of only from the init file.

Parameters:
- WIDTH, 32, token word width; also the width of the table address ports.
- SIZE, 64, number of table entries (power of two); addresses are taken modulo SIZE.
- CNT_W, $clog2(SIZE)+1, width of the count and progress fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  WIDTH  first table entry; only bits [$clog2(SIZE)-1:0] are used.
- count  in  CNT_W  number of words to write, legal range 0..SIZE.
- abort  in  1  cancels the transfer in progress.
- in_valid  in  1  in_data holds a word.
- in_data  in  WIDTH  token word.
- in_ready  out  1  loader accepts a word this cycle.
- tbl_addr  out  WIDTH  table write address; upper bits are zero.
- tbl_data  out  WIDTH  table write data.
- tbl_we  out  1  table write enable; the table writes on the posedge of clk.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag; cleared by the next accepted start.
- words_written  out  CNT_W  number of words accepted in the current or last transfer.

Behaviour:
- Reset: all registers clear asynchronously. State=IDLE; in_ready, tbl_we, busy, done, error, tbl_addr, tbl_data and words_written are all 0.
- States: IDLE, LOAD, DONE, plus VERIFY when the optional feature is compiled in.
- IDLE, start with 1<=count<=SIZE:
  - Latch base and count; clear words_written and error.
  - Next state is LOAD.
- IDLE, start with count==0: clear error; next state is DONE; no writes occur.
- IDLE, start with count>SIZE: set error; stay in IDLE; done is not pulsed.
- start is ignored in every state other than IDLE.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready. In that same cycle, combinationally: tbl_we=1, tbl_addr=(base+words_written) mod SIZE, tbl_data=in_data.
  - words_written increments on the posedge.
  - tbl_we=0 on every non-accepted cycle.
- Wrap: the address after SIZE-1 is 0.
- LOAD exit: when the accepted beat is word number count, next state is DONE (VERIFY if enabled).
- Back-to-back beats give one write per cycle. Total latency is count accepted beats plus 1 cycle of DONE.
- DONE: done=1 for exactly one cycle, in_ready=0, then IDLE.
- abort in LOAD or VERIFY:
  - Takes priority over a simultaneous beat; that beat is not accepted and not written.
  - Next state is IDLE; done is not pulsed; words_written holds its value.
- Reset mid-transfer: tbl_we and in_ready drop immediately (asynchronously); partially written entries stay in the table.

Optional Feature:
- Macro: TOKEN_LOADER_VERIFY_EN.
- When defined:
  - Adds ports tbl_rd_addr out WIDTH and tbl_rd_data in WIDTH, connected to a combinational table read port.
  - During LOAD, an XOR checksum of accepted words is accumulated.
  - VERIFY issues one address per cycle over the same count entries, XOR-accumulating tbl_rd_data. This takes count cycles, with in_ready=0.
  - At the end of VERIFY the two checksums are compared; a mismatch sets error. DONE follows either way.
- When undefined: no read ports, no VERIFY state; LOAD goes directly to DONE.

Test Plan:
- base=0, count=5, words 1..5 with in_valid held high: tbl_we high for 5 consecutive cycles at addresses 0..4; done pulses in the following cycle; words_written=5; a table read-back returns 1..5.
- Same transfer with in_valid low every other cycle: exactly 5 writes occur, and tbl_we is never high while in_valid is low.
- base=62, count=4, words A,B,C,D: writes go to addresses 62,63,0,1; done=1; error=0.
- count=0: done pulses on the next cycle with no writes. Separately, count=65: error=1, state stays IDLE, no done pulse.
- Reset asserted after 2 beats of a count=5 transfer: busy, in_ready and tbl_we drop to 0 at once. A fresh start with base=10, count=1, word 7 then writes 7 to address 10.
- With TOKEN_LOADER_VERIFY_EN, table model forced to corrupt address 2: after a count=5 transfer, VERIFY lasts 5 cycles, then error=1 and done pulses. With no corruption, error=0.
